// File: rtl/basic_gates.sv
// -----------------------------------------------------------------------------
// basic_gates
//   Bit-parallel primitive logic unit. NAND is the only primitive. NOT and AND
//   are built structurally from it. Combinational results are available with
//   zero latency. Registered copies are provided for pipelined consumers.
//
// Parameters
//   WIDTH     number of independent bit lanes (default 1)
//
// Ports
//   clk       rising-edge clock for the registered outputs
//   rst       synchronous active-high reset (clears the registered outputs only)
//   a, b      operands for NAND / AND
//   in        operand for NOT
//   nand_out  combinational ~(a & b)
//   not_out   combinational ~in
//   and_out   combinational a & b, built from NAND(NAND(a,b), NAND(a,b))
//   nand_q    registered nand_out
//   not_q     registered not_out
//   and_q     registered and_out
//   valid_q   high once the registered outputs hold post-reset data
// -----------------------------------------------------------------------------
module basic_gates #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] nand_out,
  output logic [WIDTH-1:0] not_out,
  output logic [WIDTH-1:0] and_out,
  output logic [WIDTH-1:0] nand_q,
  output logic [WIDTH-1:0] not_q,
  output logic [WIDTH-1:0] and_q,
  output logic             valid_q
);

  logic [WIDTH-1:0] w_nand_ab;
  logic [WIDTH-1:0] w_not_in;
  logic [WIDTH-1:0] w_and_ab;

  logic [WIDTH-1:0] r_nand_q;
  logic [WIDTH-1:0] r_not_q;
  logic [WIDTH-1:0] r_and_q;
  logic             r_valid_q;

  // One NAND-based cell per lane. The lanes never interact.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      // Primitive: one gate level.
      assign w_nand_ab[gi] = ~(a[gi] & b[gi]);
      // NOT is a NAND with both inputs tied together: one gate level.
      assign w_not_in[gi]  = ~(in[gi] & in[gi]);
      // AND is the NAND output fed into a second NAND acting as an inverter.
      // This gives two gate levels.
      assign w_and_ab[gi]  = ~(w_nand_ab[gi] & w_nand_ab[gi]);
    end
  endgenerate

  assign nand_out = w_nand_ab;
  assign not_out  = w_not_in;
  assign and_out  = w_and_ab;

  // The registers load on every non-reset edge; there is no enable.
  // Reset takes priority, so a value captured in the same cycle that reset is
  // asserted is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nand_q  <= '0;
      r_not_q   <= '0;
      r_and_q   <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_nand_q  <= w_nand_ab;
      r_not_q   <= w_not_in;
      r_and_q   <= w_and_ab;
      r_valid_q <= 1'b1;
    end
  end

  assign nand_q  = r_nand_q;
  assign not_q   = r_not_q;
  assign and_q   = r_and_q;
  assign valid_q = r_valid_q;

endmodule

// File: tb/tb_basic_gates.sv
// -----------------------------------------------------------------------------
// tb_basic_gates
//   Directed-vector bench for basic_gates. It uses one WIDTH=1 instance and one
//   WIDTH=4 instance. All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_basic_gates;

  logic clk = 1'b0;
  logic rst;

  logic [0:0] a1, b1, in1;
  logic [0:0] nand_out1, not_out1, and_out1, nand_q1, not_q1, and_q1;
  logic       valid_q1;

  logic [3:0] a4, b4, in4;
  logic [3:0] nand_out4, not_out4, and_out4, nand_q4, not_q4, and_q4;
  logic       valid_q4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  basic_gates #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in(in1),
    .nand_out(nand_out1), .not_out(not_out1), .and_out(and_out1),
    .nand_q(nand_q1), .not_q(not_q1), .and_q(and_q1), .valid_q(valid_q1)
  );

  basic_gates #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in(in4),
    .nand_out(nand_out4), .not_out(not_out4), .and_out(and_out4),
    .nand_q(nand_q4), .not_q(not_q4), .and_q(and_q4), .valid_q(valid_q4)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; in1 = 1'b0;
    a4 = 4'b0000; b4 = 4'b0000; in4 = 4'b0000;

    // Hold reset for two edges.
    @(posedge clk); @(posedge clk); #1;
    check("rst nand_q1", {3'b0, nand_q1}, 4'b0000);
    check("rst not_q1",  {3'b0, not_q1},  4'b0000);
    check("rst and_q1",  {3'b0, and_q1},  4'b0000);
    check("rst valid_q1", {3'b0, valid_q1}, 4'b0000);
    check("rst nand_q4", nand_q4, 4'b0000);
    check("rst not_q4",  not_q4,  4'b0000);
    check("rst and_q4",  and_q4,  4'b0000);
    check("rst valid_q4", {3'b0, valid_q4}, 4'b0000);

    // The combinational truth table is checked while reset is still asserted.
    // Reset does not affect these outputs.
    a1 = 1'b0; b1 = 1'b0; #10;
    check("ab=00 nand", {3'b0, nand_out1}, 4'b0001);
    check("ab=00 and",  {3'b0, and_out1},  4'b0000);
    a1 = 1'b1; b1 = 1'b0; #10;
    check("ab=10 nand", {3'b0, nand_out1}, 4'b0001);
    check("ab=10 and",  {3'b0, and_out1},  4'b0000);
    a1 = 1'b0; b1 = 1'b1; #10;
    check("ab=01 nand", {3'b0, nand_out1}, 4'b0001);
    check("ab=01 and",  {3'b0, and_out1},  4'b0000);
    a1 = 1'b1; b1 = 1'b1; #10;
    check("ab=11 nand", {3'b0, nand_out1}, 4'b0000);
    check("ab=11 and",  {3'b0, and_out1},  4'b0001);
    in1 = 1'b0; #10;
    check("in=0 not", {3'b0, not_out1}, 4'b0001);
    in1 = 1'b1; #10;
    check("in=1 not", {3'b0, not_out1}, 4'b0000);

    // Lane independence.
    a4 = 4'b1100; b4 = 4'b1010; in4 = 4'b0101; #10;
    check("w4 nand", nand_out4, 4'b0111);
    check("w4 and",  and_out4,  4'b1000);
    check("w4 not",  not_out4,  4'b1010);

    // Release reset with a=1, b=1, in=0. The next edge captures these values.
    @(negedge clk);
    rst = 1'b0; a1 = 1'b1; b1 = 1'b1; in1 = 1'b0;
    @(posedge clk); #1;
    check("reg nand_q1", {3'b0, nand_q1}, 4'b0000);
    check("reg and_q1",  {3'b0, and_q1},  4'b0001);
    check("reg not_q1",  {3'b0, not_q1},  4'b0001);
    check("reg valid_q1", {3'b0, valid_q1}, 4'b0001);
    check("reg nand_q4", nand_q4, 4'b0111);
    check("reg and_q4",  and_q4,  4'b1000);
    check("reg not_q4",  not_q4,  4'b1010);
    check("reg valid_q4", {3'b0, valid_q4}, 4'b0001);

    // Assert reset mid-stream while new inputs are present.
    // The in-flight value is discarded.
    a1 = 1'b0; b1 = 1'b0; in1 = 1'b1; rst = 1'b1;
    #1;
    check("midrst nand_out1", {3'b0, nand_out1}, 4'b0001);
    @(posedge clk); #1;
    check("midrst nand_q1", {3'b0, nand_q1}, 4'b0000);
    check("midrst not_q1",  {3'b0, not_q1},  4'b0000);
    check("midrst and_q1",  {3'b0, and_q1},  4'b0000);
    check("midrst valid_q1", {3'b0, valid_q1}, 4'b0000);
    check("midrst nand_q4", nand_q4, 4'b0000);
    check("midrst valid_q4", {3'b0, valid_q4}, 4'b0000);
    check("midrst nand_out1 after", {3'b0, nand_out1}, 4'b0001);

    // Release reset. The next edge captures a=0, b=0, in=1.
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel nand_q1", {3'b0, nand_q1}, 4'b0001);
    check("rel not_q1",  {3'b0, not_q1},  4'b0000);
    check("rel valid_q1", {3'b0, valid_q1}, 4'b0001);

    // A reset pulse that does not span a clock edge has no effect.
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    check("glitch valid_q1", {3'b0, valid_q1}, 4'b0001);
    check("glitch nand_q1", {3'b0, nand_q1}, 4'b0001);
    check("glitch valid_q4", {3'b0, valid_q4}, 4'b0001);

    // X-freedom. Sweep every 0/1 input combination on the 1-bit instance and
    // check both the combinational outputs and the registered outputs.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [3:0] e_nand, e_and, e_not;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; in1 = v[0];
      e_nand = (v[2] & v[1]) ? 4'b0000 : 4'b0001;
      e_and  = (v[2] & v[1]) ? 4'b0001 : 4'b0000;
      e_not  = v[0] ? 4'b0000 : 4'b0001;
      @(posedge clk); #1;
      check($sformatf("sweep%0d nand_out", i), {3'b0, nand_out1}, e_nand);
      check($sformatf("sweep%0d and_out", i),  {3'b0, and_out1},  e_and);
      check($sformatf("sweep%0d not_out", i),  {3'b0, not_out1},  e_not);
      check($sformatf("sweep%0d nand_q", i),   {3'b0, nand_q1},   e_nand);
      check($sformatf("sweep%0d and_q", i),    {3'b0, and_q1},    e_and);
      check($sformatf("sweep%0d not_q", i),    {3'b0, not_q1},    e_not);
    end

    // A second directed pattern on the 4-lane instance.
    a4 = 4'b0110; b4 = 4'b0011; in4 = 4'b1001;
    @(posedge clk); #1;
    check("w4b nand", nand_out4, 4'b1101);
    check("w4b and",  and_out4,  4'b0010);
    check("w4b not",  not_out4,  4'b0110);
    check("w4b nand_q", nand_q4, 4'b1101);
    check("w4b and_q",  and_q4,  4'b0010);
    check("w4b not_q",  not_q4,  4'b0110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
